dbg_mem_arbiter: RTL and testbench

Shares the MCU's single data-memory port and the register file's debug port between the running core and the UART debugger controller. It latches one-shot debugger requests, waits for a safe slot on the memory port (core idle, core paused, or a starvation limit reached) and stalls the core while it owns the port. It returns read data and a busy/done handshake to the controller. Sits between the controller FSM outputs and the MCU memory/register-file interfaces.

---
 rtl/dbg_pkg.sv | 47 ++++
 rtl/dbg_starve_ctr.sv | 32 +++
 rtl/dbg_mem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dbg_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debugger memory/register-file arbiter.
// Optional starvation limit is enabled with the DBG_ARB_STARVE_EN macro (see dbg_mem_arbiter).
package dbg_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PEND      = 3'd1,
        ST_MEM_ISSUE = 3'd2,
        ST_MEM_WAIT  = 3'd3,
        ST_REG_ACC   = 3'd4
    } arb_state_t;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_MEM_RD = 3'd1,
        OP_MEM_WR = 3'd2,
        OP_REG_RD = 3'd3,
        OP_REG_WR = 3'd4
    } op_t;

    function automatic logic op_is_mem(input op_t op);
        logic r;
        case (op)
            OP_MEM_RD: r = 1'b1;
            OP_MEM_WR: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_reg(input op_t op);
        logic r;
        case (op)
            OP_REG_RD: r = 1'b1;
            OP_REG_WR: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dbg_starve_ctr.sv
// Saturating wait counter for a pending debugger memory request; hit flags the limit.
// Only instantiated when DBG_ARB_STARVE_EN is defined.
module dbg_starve_ctr #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CNT_W = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Saturating count; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_W'(MAX))) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign hit = (cnt_r == CNT_W'(MAX));

endmodule

// File: rtl/dbg_mem_arbiter.sv
// Arbitrates the data-memory port and register-file debug port between the core and the debugger.
// Define DBG_ARB_STARVE_EN to force a grant after STARVE_MAX cycles of core traffic.
module dbg_mem_arbiter
    import dbg_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 db_valid,
    input  logic                 db_mem_rd,
    input  logic                 db_mem_wr,
    input  logic                 db_reg_rd,
    input  logic                 db_reg_wr,
    input  logic [1:0]           db_size,
    input  logic [ADDR_W-1:0]    db_addr,
    input  logic [DATA_W-1:0]    db_wdata,
    output logic                 db_busy,
    output logic                 db_err,
    output logic [DATA_W-1:0]    db_rdata,
    input  logic                 core_paused,
    input  logic                 core_mem_rd,
    input  logic                 core_mem_wr,
    input  logic [1:0]           core_size,
    input  logic [ADDR_W-1:0]    core_addr,
    input  logic [DATA_W-1:0]    core_wdata,
    output logic                 core_stall,
    output logic [DATA_W-1:0]    core_rdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [1:0]           mem_size,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 rf_rd,
    output logic                 rf_wr,
    output logic [REG_IDX_W-1:0] rf_addr,
    output logic [DATA_W-1:0]    rf_wdata,
    input  logic [DATA_W-1:0]    rf_rdata
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t          state_r;
    op_t                 op_r;
    logic [1:0]          size_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                busy_r;
    logic                err_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [LAT_W-1:0]    lat_cnt_r;

    op_t                 req_op_s;
    logic                req_ok_s;
    logic                accept_s;
    logic                grant_s;
    logic                starve_clr_s;
    logic                starve_inc_s;
    logic                starve_hit_s;

    // Memory returns data low-aligned; narrow accesses are zero-extended
    function automatic logic [DATA_W-1:0] zext_by_size(input logic [DATA_W-1:0] d,
                                                       input logic [1:0] sz);
        logic [DATA_W-1:0] r;
        case (sz)
            SZ_BYTE: r = {{(DATA_W-8){1'b0}}, d[7:0]};
            SZ_HALF: r = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request decode: exactly one op bit, and register ops only against a paused core
    always_comb begin
        req_op_s = OP_NONE;
        req_ok_s = 1'b0;
        case ({db_mem_rd, db_mem_wr, db_reg_rd, db_reg_wr})
            4'b1000: req_op_s = OP_MEM_RD;
            4'b0100: req_op_s = OP_MEM_WR;
            4'b0010: req_op_s = OP_REG_RD;
            4'b0001: req_op_s = OP_REG_WR;
            default: req_op_s = OP_NONE;
        endcase
        if (req_op_s == OP_NONE) begin
            req_ok_s = 1'b0;
        end else if (op_is_reg(req_op_s) && !core_paused) begin
            req_ok_s = 1'b0;
        end else begin
            req_ok_s = 1'b1;
        end
    end

    // A busy flag in IDLE means a rejected request is still being retired
    assign accept_s     = (state_r == ST_IDLE) && !busy_r && db_valid;
    assign grant_s      = core_paused || !(core_mem_rd || core_mem_wr) || starve_hit_s;
    assign starve_clr_s = accept_s && req_ok_s && op_is_mem(req_op_s);
    assign starve_inc_s = (state_r == ST_PEND) && !grant_s;

`ifdef DBG_ARB_STARVE_EN
    dbg_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .clr (starve_clr_s),
        .inc (starve_inc_s),
        .hit (starve_hit_s)
    );
`else
    logic starve_unused_s;
    assign starve_hit_s    = 1'b0;
    assign starve_unused_s = ^{starve_clr_s, starve_inc_s, 32'(STARVE_MAX)};
`endif

    // Request FSM: latching, port ownership and completion handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_NONE;
            size_r    <= 2'd0;
            addr_r    <= '0;
            wdata_r   <= '0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
            lat_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (db_valid) begin
                        op_r    <= req_op_s;
                        size_r  <= db_size;
                        addr_r  <= db_addr;
                        wdata_r <= db_wdata;
                        busy_r  <= 1'b1;
                        if (!req_ok_s) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r   <= 1'b0;
                            state_r <= op_is_mem(req_op_s) ? ST_PEND : ST_REG_ACC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (grant_s) begin
                        state_r <= ST_MEM_ISSUE;
                    end else begin
                        state_r <= ST_PEND;
                    end
                end
                ST_MEM_ISSUE: begin
                    if (op_r == OP_MEM_WR) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        lat_cnt_r <= '0;
                        state_r   <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (lat_cnt_r == LAT_W'(MEM_LAT - 1)) begin
                        rdata_r <= zext_by_size(mem_rdata, size_r);
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_REG_ACC: begin
                    if (op_r == OP_REG_RD) begin
                        rdata_r <= rf_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port mux: the debugger drives the port only for its single issue cycle
    always_comb begin
        mem_rd    = core_mem_rd;
        mem_wr    = core_mem_wr;
        mem_size  = core_size;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        if (state_r == ST_MEM_ISSUE) begin
            mem_rd    = (op_r == OP_MEM_RD);
            mem_wr    = (op_r == OP_MEM_WR);
            mem_size  = size_r;
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
        end else begin
            mem_rd    = core_mem_rd;
            mem_wr    = core_mem_wr;
            mem_size  = core_size;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    assign core_stall = (state_r == ST_MEM_ISSUE) || (state_r == ST_MEM_WAIT);
    assign core_rdata = mem_rdata;

    // x0 is hardwired, so its write strobe is dropped while the request still completes
    assign rf_addr  = addr_r[REG_IDX_W-1:0];
    assign rf_wdata = wdata_r;
    assign rf_rd    = (state_r == ST_REG_ACC) && (op_r == OP_REG_RD);
    assign rf_wr    = (state_r == ST_REG_ACC) && (op_r == OP_REG_WR) &&
                      (addr_r[REG_IDX_W-1:0] != 5'd0);

    assign db_busy  = busy_r;
    assign db_err   = err_r;
    assign db_rdata = rdata_r;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Directed self-checking bench for dbg_mem_arbiter (MEM_LAT=1, STARVE_MAX=15).
module tb_dbg_mem_arbiter;

    logic        clk, rst;
    logic        db_valid, db_mem_rd, db_mem_wr, db_reg_rd, db_reg_wr;
    logic [1:0]  db_size;
    logic [31:0] db_addr, db_wdata;
    logic        db_busy, db_err;
    logic [31:0] db_rdata;
    logic        core_paused, core_mem_rd, core_mem_wr;
    logic [1:0]  core_size;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rf_rd, rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .db_valid(db_valid), .db_mem_rd(db_mem_rd), .db_mem_wr(db_mem_wr),
        .db_reg_rd(db_reg_rd), .db_reg_wr(db_reg_wr), .db_size(db_size),
        .db_addr(db_addr), .db_wdata(db_wdata), .db_busy(db_busy), .db_err(db_err),
        .db_rdata(db_rdata), .core_paused(core_paused), .core_mem_rd(core_mem_rd),
        .core_mem_wr(core_mem_wr), .core_size(core_size), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rf_rd(rf_rd), .rf_wr(rf_wr),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // Register file model: each register reads back a tagged copy of its index
    assign rf_rdata = 32'hCAFE_0000 | {27'd0, rf_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_db();
        db_valid = 1'b0; db_mem_rd = 1'b0; db_mem_wr = 1'b0;
        db_reg_rd = 1'b0; db_reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_db(); db_size = 2'd0; db_addr = 32'd0; db_wdata = 32'd0;
        core_paused = 1'b0; core_mem_rd = 1'b1; core_mem_wr = 1'b0; core_size = 2'd2;
        core_addr = 32'h44; core_wdata = 32'h1111_2222; mem_rdata = 32'h0;
        #12;
        n_checks++; if (db_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", db_busy); end
        n_checks++; if (db_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0h exp=0", db_err); end
        n_checks++; if (db_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%0h exp=0", db_rdata); end
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0h exp=0", core_stall); end
        n_checks++; if ({rf_rd, rf_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_rf got=%0b exp=00", {rf_rd, rf_wr}); end
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL rst_mirror got=%0h/%0h exp=1/44", mem_rd, mem_addr); end
        n_checks++; if (mem_wdata !== 32'h1111_2222) begin n_fail++; $display("FAIL rst_mirror_wd got=%0h exp=11112222", mem_wdata); end
        core_mem_rd = 1'b0;
        tick(); rst = 1'b0; tick();
    endtask

    task automatic test_mem_write();
        core_paused = 1'b0; core_mem_rd = 1'b0; core_addr = 32'h10;
        db_valid = 1'b1; db_mem_wr = 1'b1; db_size = 2'd2; db_addr = 32'h100; db_wdata = 32'hDEAD_BEEF;
        sample();
        n_checks++; if (db_busy !== 1'b0) begin n_fail++; $display("FAIL wr_c0_busy got=%0h exp=0", db_busy); end
        tick(); clear_db(); sample();
        n_checks++; if ({db_busy, core_stall, mem_wr} !== 3'b100) begin n_fail++; $display("FAIL wr_c1 busy/stall/wr got=%0b exp=100", {db_busy, core_stall, mem_wr}); end
        tick(); sample();
        n_checks++; if ({mem_wr, mem_rd, core_stall} !== 3'b101) begin n_fail++; $display("FAIL wr_c2 wr/rd/stall got=%0b exp=101", {mem_wr, mem_rd, core_stall}); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL wr_c2_addr got=%0h exp=100", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_c2_wdata got=%0h exp=deadbeef", mem_wdata); end
        n_checks++; if (mem_size !== 2'd2) begin n_fail++; $display("FAIL wr_c2_size got=%0h exp=2", mem_size); end
        tick(); sample();
        n_checks++; if ({db_busy, core_stall, mem_wr} !== 3'b000) begin n_fail++; $display("FAIL wr_c3 busy/stall/wr got=%0b exp=000", {db_busy, core_stall, mem_wr}); end
        n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL wr_c3_addr got=%0h exp=10", mem_addr); end
        tick();
    endtask

    task automatic test_mem_read();
        // Core paused but still asserting a read: the pause alone must grant
        core_paused = 1'b1; core_mem_rd = 1'b1; core_addr = 32'h80; mem_rdata = 32'h1234_56EF;
        db_valid = 1'b1; db_mem_rd = 1'b1; db_size = 2'd0; db_addr = 32'h100;
        tick(); clear_db(); sample();
        n_checks++; if ({db_busy, core_stall} !== 2'b10) begin n_fail++; $display("FAIL rd_c1 busy/stall got=%0b exp=10", {db_busy, core_stall}); end
        tick(); sample();
        n_checks++; if ({mem_rd, mem_wr, core_stall} !== 3'b101) begin n_fail++; $display("FAIL rd_c2 rd/wr/stall got=%0b exp=101", {mem_rd, mem_wr, core_stall}); end
        n_checks++; if ({mem_addr, mem_size} !== {32'h100, 2'd0}) begin n_fail++; $display("FAIL rd_c2 addr/size got=%0h/%0h exp=100/0", mem_addr, mem_size); end
        tick(); sample();
        n_checks++; if ({db_busy, core_stall} !== 2'b11) begin n_fail++; $display("FAIL rd_c3 busy/stall got=%0b exp=11", {db_busy, core_stall}); end
        n_checks++; if (mem_addr !== 32'h80) begin n_fail++; $display("FAIL rd_c3_addr got=%0h exp=80", mem_addr); end
        n_checks++; if (core_rdata !== 32'h1234_56EF) begin n_fail++; $display("FAIL rd_core_rdata got=%0h exp=123456ef", core_rdata); end
        tick(); sample();
        n_checks++; if ({db_busy, core_stall} !== 2'b00) begin n_fail++; $display("FAIL rd_c4 busy/stall got=%0b exp=00", {db_busy, core_stall}); end
        n_checks++; if (db_rdata !== 32'h0000_00EF) begin n_fail++; $display("FAIL rd_c4_rdata got=%0h exp=ef", db_rdata); end
        core_paused = 1'b0; core_mem_rd = 1'b0;
        tick();
    endtask

    task automatic test_half_read();
        mem_rdata = 32'h1234_BEEF;
        db_valid = 1'b1; db_mem_rd = 1'b1; db_size = 2'd1; db_addr = 32'h202;
        tick(); clear_db(); tick(); tick(); sample();
        n_checks++; if (db_busy !== 1'b1) begin n_fail++; $display("FAIL half_c3_busy got=%0h exp=1", db_busy); end
        tick(); sample();
        n_checks++; if ({db_busy, db_rdata} !== {1'b0, 32'h0000_BEEF}) begin n_fail++; $display("FAIL half_c4 busy/rdata got=%0h/%0h exp=0/beef", db_busy, db_rdata); end
        tick();
    endtask

    task automatic test_starve();
        core_mem_rd = 1'b1; core_addr = 32'h200;
        db_valid = 1'b1; db_mem_wr = 1'b1; db_size = 2'd2; db_addr = 32'h300; db_wdata = 32'h55;
`ifdef DBG_ARB_STARVE_EN
        for (int k = 1; k <= 16; k++) begin
            tick(); clear_db(); sample();
            n_checks++; if ({core_stall, mem_addr} !== {1'b0, 32'h200}) begin n_fail++; $display("FAIL starve_pend_c%0d stall/addr got=%0h/%0h exp=0/200", k, core_stall, mem_addr); end
        end
        tick(); sample();
        n_checks++; if ({core_stall, mem_wr, mem_rd, mem_addr} !== {3'b110, 32'h300}) begin n_fail++; $display("FAIL starve_c17 stall/wr/rd/addr got=%0b/%0h exp=110/300", {core_stall, mem_wr, mem_rd}, mem_addr); end
        tick(); sample();
        n_checks++; if ({db_busy, core_stall, mem_rd, mem_addr} !== {3'b001, 32'h200}) begin n_fail++; $display("FAIL starve_c18 busy/stall/rd/addr got=%0b/%0h exp=001/200", {db_busy, core_stall, mem_rd}, mem_addr); end
`else
        for (int k = 1; k <= 20; k++) begin
            tick(); clear_db(); sample();
            n_checks++; if ({core_stall, db_busy, mem_addr} !== {2'b01, 32'h200}) begin n_fail++; $display("FAIL starve_pend_c%0d stall/busy/addr got=%0b/%0h exp=01/200", k, {core_stall, db_busy}, mem_addr); end
        end
        tick(); core_mem_rd = 1'b0; tick(); sample();
        n_checks++; if ({core_stall, mem_wr, mem_addr} !== {2'b11, 32'h300}) begin n_fail++; $display("FAIL starve_issue stall/wr/addr got=%0b/%0h exp=11/300", {core_stall, mem_wr}, mem_addr); end
        tick(); sample();
        n_checks++; if ({db_busy, core_stall} !== 2'b00) begin n_fail++; $display("FAIL starve_done busy/stall got=%0b exp=00", {db_busy, core_stall}); end
`endif
        core_mem_rd = 1'b0;
        tick();
    endtask

    task automatic test_reg();
        core_paused = 1'b0;
        db_valid = 1'b1; db_reg_wr = 1'b1; db_addr = 32'd5; db_wdata = 32'd7;
        tick(); clear_db(); sample();
        n_checks++; if ({db_err, rf_wr, db_busy} !== 3'b101) begin n_fail++; $display("FAIL reg_unpaused err/rf_wr/busy got=%0b exp=101", {db_err, rf_wr, db_busy}); end
        tick(); sample();
        n_checks++; if ({db_busy, rf_wr} !== 2'b00) begin n_fail++; $display("FAIL reg_unpaused_c2 busy/rf_wr got=%0b exp=00", {db_busy, rf_wr}); end
        core_paused = 1'b1;
        db_valid = 1'b1; db_reg_wr = 1'b1;
        tick(); clear_db(); sample();
        n_checks++; if ({rf_wr, rf_rd, db_err, rf_addr} !== {3'b100, 5'd5}) begin n_fail++; $display("FAIL reg_wr wr/rd/err/addr got=%0b/%0d exp=100/5", {rf_wr, rf_rd, db_err}, rf_addr); end
        n_checks++; if (rf_wdata !== 32'd7) begin n_fail++; $display("FAIL reg_wr_wdata got=%0h exp=7", rf_wdata); end
        tick(); sample();
        n_checks++; if ({db_busy, rf_wr} !== 2'b00) begin n_fail++; $display("FAIL reg_wr_c2 busy/rf_wr got=%0b exp=00", {db_busy, rf_wr}); end
        db_valid = 1'b1; db_reg_wr = 1'b1; db_addr = 32'd0;
        tick(); clear_db(); sample();
        n_checks++; if ({rf_wr, db_busy} !== 2'b01) begin n_fail++; $display("FAIL reg_x0 rf_wr/busy got=%0b exp=01", {rf_wr, db_busy}); end
        tick(); sample();
        n_checks++; if (db_busy !== 1'b0) begin n_fail++; $display("FAIL reg_x0_c2_busy got=%0h exp=0", db_busy); end
        db_valid = 1'b1; db_reg_rd = 1'b1; db_addr = 32'd9;
        tick(); clear_db(); sample();
        n_checks++; if ({rf_rd, rf_wr, rf_addr} !== {2'b10, 5'd9}) begin n_fail++; $display("FAIL reg_rd rd/wr/addr got=%0b/%0d exp=10/9", {rf_rd, rf_wr}, rf_addr); end
        tick(); sample();
        n_checks++; if ({db_busy, db_rdata} !== {1'b0, 32'hCAFE_0009}) begin n_fail++; $display("FAIL reg_rd_c2 busy/rdata got=%0h/%0h exp=0/cafe0009", db_busy, db_rdata); end
        tick();
    endtask

    task automatic test_reject_combo();
        core_paused = 1'b1; core_mem_rd = 1'b0;
        db_valid = 1'b1; db_mem_rd = 1'b1; db_reg_rd = 1'b1; db_addr = 32'h44;
        tick(); clear_db();
        // A legal request while the rejection is retiring must be ignored
        db_valid = 1'b1; db_mem_wr = 1'b1; db_addr = 32'h88;
        sample();
        n_checks++; if ({db_err, db_busy, mem_rd, rf_rd} !== 4'b1100) begin n_fail++; $display("FAIL combo_c1 err/busy/mem_rd/rf_rd got=%0b exp=1100", {db_err, db_busy, mem_rd, rf_rd}); end
        tick(); clear_db(); sample();
        n_checks++; if ({db_busy, mem_rd, rf_rd} !== 3'b000) begin n_fail++; $display("FAIL combo_c2 busy/mem_rd/rf_rd got=%0b exp=000", {db_busy, mem_rd, rf_rd}); end
        tick(); sample();
        n_checks++; if ({db_busy, mem_wr, core_stall} !== 3'b000) begin n_fail++; $display("FAIL combo_ignored busy/wr/stall got=%0b exp=000", {db_busy, mem_wr, core_stall}); end
        core_paused = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        core_paused = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        db_valid = 1'b1; db_mem_rd = 1'b1; db_size = 2'd2; db_addr = 32'h40;
        tick(); clear_db(); tick(); tick(); sample();
        n_checks++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_wait_stall got=%0h exp=1", core_stall); end
        rst = 1'b1;
        #1;
        n_checks++; if ({db_busy, core_stall, db_rdata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL rmid_abort busy/stall/rdata got=%0b/%0h exp=00/0", {db_busy, core_stall}, db_rdata); end
        tick(); rst = 1'b0; core_paused = 1'b0;
        db_valid = 1'b1; db_mem_wr = 1'b1; db_addr = 32'h500; db_wdata = 32'h0BAD_F00D;
        tick(); clear_db(); tick(); sample();
        n_checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h500, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rmid_wr_c2 wr/addr/wdata got=%0h/%0h/%0h exp=1/500/badf00d", mem_wr, mem_addr, mem_wdata); end
        tick(); sample();
        n_checks++; if (db_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_c3_busy got=%0h exp=0", db_busy); end
        mem_rdata = 32'hA1B2_C3D4;
        db_valid = 1'b1; db_mem_rd = 1'b1; db_size = 2'd2; db_addr = 32'h504;
        tick(); clear_db(); tick(); tick(); tick(); sample();
        n_checks++; if ({db_busy, db_rdata} !== {1'b0, 32'hA1B2_C3D4}) begin n_fail++; $display("FAIL rmid_rd_c4 busy/rdata got=%0h/%0h exp=0/a1b2c3d4", db_busy, db_rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_mem_read();
        test_half_read();
        test_starve();
        test_reg();
        test_reject_combo();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
